// File: rtl/uc_pkg.sv
// Shared constants for the micro-controller control unit:
// opcodes, ALU operation codes and the FSM state type.
`timescale 1ns/1ps
package uc_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_ERR  = 2'b10
    } uc_state_e;

    localparam logic [5:0] OPC_J    = 6'b000000;
    localparam logic [5:0] OPC_JZ   = 6'b000001;
    localparam logic [5:0] OPC_JNZ  = 6'b000010;
    localparam logic [5:0] OPC_HALT = 6'b000011;
    localparam logic [5:0] OPC_NOP  = 6'b000100;
    localparam logic [3:0] OPC_LI   = 4'b0100;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_NOT  = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_NEGA = 3'b110;
    localparam logic [2:0] ALU_NEGB = 3'b111;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/uc_fsm_if.sv
// Bundle between the state/counter owner (master) and the
// combinational opcode decoder (slave).
`timescale 1ns/1ps
import uc_pkg::*;

interface uc_fsm_if;
    logic [5:0] opcode;
    logic       z;
    logic       start;
    uc_state_e  state;
    uc_state_e  nxt;
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op;
    logic       retire;
    logic       jmp_taken;

    modport master (
        output opcode, z, start, state,
        input  nxt, s_inc, s_inm, we3, wez, op,
        input  retire, jmp_taken
    );

    modport slave (
        input  opcode, z, start, state,
        output nxt, s_inc, s_inm, we3, wez, op,
        output retire, jmp_taken
    );
endinterface

// File: rtl/uc_deco.sv
// Combinational opcode/state decoder: control word, next state
// and retire/jump-taken strobes for the performance counters.
`timescale 1ns/1ps
import uc_pkg::*;

module uc_deco (
    uc_fsm_if.slave bus
);

    logic [5:0] opc;
    uc_state_e  nxt;
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op;
    logic       retire;
    logic       jmp;

    assign opc = bus.opcode;

    always_comb begin
        nxt    = bus.state;
        s_inc  = 1'b0;
        s_inm  = 1'b0;
        we3    = 1'b0;
        wez    = 1'b0;
        op     = ALU_PASS;
        retire = 1'b0;
        jmp    = 1'b0;
        unique case (bus.state)
            ST_RUN: begin
                unique case (1'b1)
                    opc[5]: begin
                        op     = opc[4:2];
                        we3    = 1'b1;
                        wez    = 1'b1;
                        s_inc  = 1'b1;
                        retire = 1'b1;
                    end
                    (opc[5:2] == OPC_LI): begin
                        we3    = 1'b1;
                        s_inm  = 1'b1;
                        s_inc  = 1'b1;
                        retire = 1'b1;
                    end
                    (opc == OPC_J): begin
                        retire = 1'b1;
                        jmp    = 1'b1;
                    end
                    (opc == OPC_JZ): begin
                        s_inc  = ~bus.z;
                        retire = 1'b1;
                        jmp    = bus.z;
                    end
                    (opc == OPC_JNZ): begin
                        s_inc  = bus.z;
                        retire = 1'b1;
                        jmp    = ~bus.z;
                    end
                    // PC holds: the HALT target is its own address
                    (opc == OPC_HALT): begin
                        retire = 1'b1;
                        nxt    = ST_HALT;
                    end
                    (opc == OPC_NOP): begin
                        s_inc  = 1'b1;
                        retire = 1'b1;
                    end
                    default: nxt = ST_ERR;
                endcase
            end
            ST_HALT: begin
                if (bus.start) begin
                    s_inc = 1'b1;
                    nxt   = ST_RUN;
                end
            end
            default: nxt = ST_ERR;
        endcase
    end

    assign bus.nxt       = nxt;
    assign bus.s_inc     = s_inc;
    assign bus.s_inm     = s_inm;
    assign bus.we3       = we3;
    assign bus.wez       = wez;
    assign bus.op        = op;
    assign bus.retire    = retire;
    assign bus.jmp_taken = jmp;

endmodule

// File: rtl/uc_fsm.sv
// Control unit top: RUN/HALT/ERROR state register, reset gating
// and optional saturating counters (macro UC_PERF_CNT_EN).
`timescale 1ns/1ps
import uc_pkg::*;

module uc_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic        z,
    input  logic        start,
    output logic        s_inc,
    output logic        s_inm,
    output logic        we3,
    output logic        wez,
    output logic [2:0]  Op,
    output logic        halted,
    output logic        err,
    output logic [15:0] cyc_cnt,
    output logic [15:0] ret_cnt,
    output logic [15:0] jmp_cnt
);

    uc_state_e state_q;

    uc_fsm_if bus ();

    assign bus.opcode = Opcode;
    assign bus.z      = z;
    assign bus.start  = start;
    assign bus.state  = state_q;

    uc_deco u_deco (
        .bus (bus.slave)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_RUN;
        else        state_q <= bus.nxt;
    end

    // Reset overrides the decode asynchronously, not just at the edge
    assign s_inc  = reset ? bus.s_inc : 1'b1;
    assign s_inm  = reset & bus.s_inm;
    assign we3    = reset & bus.we3;
    assign wez    = reset & bus.wez;
    assign Op     = reset ? bus.op : ALU_PASS;
    assign halted = reset & (state_q == ST_HALT);
    assign err    = reset & (state_q == ST_ERR);

`ifdef UC_PERF_CNT_EN
    logic [15:0] cyc_q;
    logic [15:0] ret_q;
    logic [15:0] jmp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
            ret_q <= '0;
            jmp_q <= '0;
        end else begin
            cyc_q <= sat_inc(cyc_q);
            if (bus.retire)    ret_q <= sat_inc(ret_q);
            if (bus.jmp_taken) jmp_q <= sat_inc(jmp_q);
        end
    end

    assign cyc_cnt = cyc_q;
    assign ret_cnt = ret_q;
    assign jmp_cnt = jmp_q;
`else
    logic unused_perf;
    assign unused_perf = bus.retire ^ bus.jmp_taken;

    assign cyc_cnt = '0;
    assign ret_cnt = '0;
    assign jmp_cnt = '0;
`endif

endmodule

// File: tb/tb_uc_fsm.sv
// Randomized scoreboard bench for uc_fsm against a behavioural
// model of the RUN/HALT/ERROR control rules.
`timescale 1ns/1ps

module tb_uc_fsm;

    typedef struct packed {
        logic        s_inc;
        logic        s_inm;
        logic        we3;
        logic        wez;
        logic [2:0]  op;
        logic        halted;
        logic        err;
        logic [15:0] cyc;
        logic [15:0] ret;
        logic [15:0] jmp;
    } exp_t;

`ifdef UC_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        s_inc, s_inm, we3, wez;
    logic [2:0]  Op;
    logic        halted, err;
    logic [15:0] cyc_cnt, ret_cnt, jmp_cnt;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb[$];

    bit m_halt;
    bit m_err;
    int c_cyc, c_ret, c_jmp;

    uc_fsm_if tb_bus ();

    uc_fsm dut (
        .clk     (clk),
        .reset   (reset),
        .Opcode  (tb_bus.opcode),
        .z       (tb_bus.z),
        .start   (tb_bus.start),
        .s_inc   (s_inc),
        .s_inm   (s_inm),
        .we3     (we3),
        .wez     (wez),
        .Op      (Op),
        .halted  (halted),
        .err     (err),
        .cyc_cnt (cyc_cnt),
        .ret_cnt (ret_cnt),
        .jmp_cnt (jmp_cnt)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Expected outputs for this cycle, then advance to the next edge
    task automatic model_step(input logic r, input logic [5:0] opc,
                              input logic zz, input logic st,
                              output exp_t e);
        int o;
        bit ret;
        bit jmp;
        e = '0;
        ret = 1'b0;
        jmp = 1'b0;
        o = int'(opc);
        if (!r) begin
            m_halt = 1'b0;
            m_err  = 1'b0;
            c_cyc  = 0;
            c_ret  = 0;
            c_jmp  = 0;
            e.s_inc = 1'b1;
            return;
        end
        e.halted = m_halt;
        e.err    = m_err;
        e.cyc    = PERF ? 16'(c_cyc) : 16'd0;
        e.ret    = PERF ? 16'(c_ret) : 16'd0;
        e.jmp    = PERF ? 16'(c_jmp) : 16'd0;
        if (m_err) begin
            e.s_inc = 1'b0;
        end else if (m_halt) begin
            e.s_inc = st;
            if (st) m_halt = 1'b0;
        end else if (o >= 32) begin
            e.op  = 3'((o / 4) % 8);
            e.we3 = 1'b1;
            e.wez = 1'b1;
            e.s_inc = 1'b1;
            ret = 1'b1;
        end else if (o >= 16 && o <= 19) begin
            e.we3   = 1'b1;
            e.s_inm = 1'b1;
            e.s_inc = 1'b1;
            ret = 1'b1;
        end else if (o == 0) begin
            ret = 1'b1;
            jmp = 1'b1;
        end else if (o == 1) begin
            e.s_inc = !zz;
            ret = 1'b1;
            jmp = zz;
        end else if (o == 2) begin
            e.s_inc = zz;
            ret = 1'b1;
            jmp = !zz;
        end else if (o == 3) begin
            ret = 1'b1;
            m_halt = 1'b1;
        end else if (o == 4) begin
            e.s_inc = 1'b1;
            ret = 1'b1;
        end else begin
            m_err = 1'b1;
        end
        c_cyc = sat(c_cyc);
        if (ret) c_ret = sat(c_ret);
        if (jmp) c_jmp = sat(c_jmp);
    endtask

    task automatic drive(input logic r, input logic [5:0] opc,
                         input logic zz, input logic st);
        exp_t e;
        @(negedge clk);
        reset = r;
        tb_bus.opcode = opc;
        tb_bus.z = zz;
        tb_bus.start = st;
        model_step(r, opc, zz, st, e);
        sb.push_back(e);
    endtask

    function automatic logic [5:0] pick_opc();
        int r;
        logic [5:0] v;
        r = $urandom_range(0, 99);
        if (r < 35)      v = {1'b1, 5'($urandom_range(0, 31))};
        else if (r < 50) v = {4'b0100, 2'($urandom_range(0, 3))};
        else if (r < 60) v = 6'd0;
        else if (r < 70) v = 6'd1;
        else if (r < 80) v = 6'd2;
        else if (r < 88) v = 6'd4;
        else if (r < 97) v = 6'd3;
        else if (r < 98) v = 6'($urandom_range(5, 15));
        else             v = 6'($urandom_range(20, 31));
        return v;
    endfunction

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {s_inc, s_inm, we3, wez, Op, halted, err,
                     cyc_cnt, ret_cnt, jmp_cnt};
                n_checks++;
                if (a !== e) begin
                    n_errors++;
                    $display("FAIL scoreboard t=%0t got s_inc=%b s_inm=%b we3=%b wez=%b op=%0d halted=%b err=%b cyc=%0d ret=%0d jmp=%0d | exp s_inc=%b s_inm=%b we3=%b wez=%b op=%0d halted=%b err=%b cyc=%0d ret=%0d jmp=%0d",
                             $time, a.s_inc, a.s_inm, a.we3, a.wez, a.op,
                             a.halted, a.err, a.cyc, a.ret, a.jmp,
                             e.s_inc, e.s_inm, e.we3, e.wez, e.op,
                             e.halted, e.err, e.cyc, e.ret, e.jmp);
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    task automatic check(input string name, input logic act,
                         input logic req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s got=%b exp=%b", name, act, req);
        end
    endtask

    initial begin : stim
        reset = 1'b0;
        tb_bus.opcode = 6'd4;
        tb_bus.z = 1'b0;
        tb_bus.start = 1'b0;

        drive(0, 6'b100101, 0, 0);
        drive(0, 6'b100101, 0, 1);
        drive(1, 6'b100101, 0, 0);
        drive(1, 6'b010010, 0, 0);
        drive(1, 6'b000001, 1, 0);
        drive(1, 6'b000001, 0, 0);
        drive(1, 6'b000010, 0, 1);
        drive(1, 6'b000011, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, pick_opc(), 1'($urandom), 0);
        drive(1, 6'b000111, 0, 1);
        drive(1, 6'b000100, 0, 0);
        drive(1, 6'b000111, 0, 0);
        for (int i = 0; i < 4; i++)
            drive(1, pick_opc(), 1'($urandom), 1'($urandom));
        drive(0, 6'b000011, 0, 0);
        drive(1, 6'b000011, 0, 0);
        drive(0, 6'b000100, 0, 1);
        drive(1, 6'b111111, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            logic r;
            r = ($urandom_range(0, 49) != 0);
            drive(r, pick_opc(), 1'($urandom),
                  ($urandom_range(0, 3) == 0));
        end

        if (PERF) begin
            drive(0, 6'd4, 0, 0);
            for (int i = 0; i < 70000; i++)
                drive(1, (i % 2 == 0) ? 6'd4 : 6'd0, 0, 0);
        end

        drive(0, 6'd4, 0, 0);
        drive(1, 6'd3, 0, 0);
        drive(1, 6'b100001, 0, 0);
        #4;
        check("halt_before_async_reset", halted, 1'b1);
        reset = 1'b0;
        #1;
        check("async_reset_halted", halted, 1'b0);
        check("async_reset_we3", we3, 1'b0);
        check("async_reset_s_inc", s_inc, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("run_after_release", halted | err, 1'b0);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uc_fsm.md
UC_FSM -- requirements
Module: uc_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = asserted).
REQ-003 SHALL have port Opcode, input, 6 bits: instruction[15:10] from the datapath.
REQ-004 SHALL have port z, input, 1 bit: registered zero flag from the datapath.
REQ-005 SHALL have port start, input, 1 bit: resume request, sampled only in HALT.
REQ-006 SHALL have ports s_inc (1 = PC+1, 0 = jump target), s_inm (1 = immediate to register file), we3, wez, all outputs, 1 bit each.
REQ-007 SHALL have port Op, output, 3 bits: ALU operation select.
REQ-008 SHALL have ports halted and err, outputs, 1 bit each: status flags.
REQ-009 SHALL have ports cyc_cnt, ret_cnt and jmp_cnt, outputs, 16 bits each: performance counters.

Function
REQ-010 SHALL produce the control outputs combinationally from Opcode, z and the registered state, giving zero-latency control for the single-cycle datapath.
REQ-011 SHALL decode Opcode 1xxxxx (ALU) in RUN as: Op=Opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=1.
REQ-012 SHALL decode Opcode 0100xx (LI) in RUN as: we3=1, s_inm=1, wez=0, s_inc=1, Op=000.
REQ-013 SHALL decode Opcode 000000 (J) in RUN as s_inc=0; JZ 000001 as s_inc=~z; JNZ 000010 as s_inc=z; all three with we3=wez=0.
REQ-014 SHALL decode Opcode 000100 (NOP) in RUN as s_inc=1 with all writes disabled.
REQ-015 SHALL decode Opcode 000011 (HALT) in RUN as s_inc=0 with writes disabled; the assembler encodes the HALT target as its own address, and the next state is HALT.
REQ-016 SHALL implement the states RUN, HALT and ERROR; any Opcode not listed in REQ-011..015 in RUN SHALL drive writes 0 and s_inc=0, and the next state SHALL be ERROR.
REQ-017 In HALT with start=0, SHALL drive s_inc=0, we3=0 and wez=0, so the PC re-fetches the HALT instruction.
REQ-018 In HALT with start=1, SHALL drive s_inc=1 with writes disabled, and the next state SHALL be RUN.
REQ-019 In ERROR, SHALL drive s_inc=0 with writes disabled; ERROR SHALL be left only by reset.
REQ-020 SHALL ignore start in RUN and ERROR; start asserted in the same cycle a HALT is decoded in RUN SHALL be ignored, so the transition to HALT occurs and a new pulse is needed.
REQ-021 SHALL drive halted=1 exactly while the state is HALT and err=1 exactly while the state is ERROR.

Reset
REQ-022 While reset=0, SHALL force state=RUN, we3=0, wez=0, s_inm=0, s_inc=1, Op=000, halted=0, err=0 and all counters to 0.
REQ-023 Reset asserted in HALT or ERROR SHALL return the block to RUN on the first rising edge after release.

Configuration
REQ-024 With macro UC_PERF_CNT_EN defined, SHALL implement the three 16-bit counters; each SHALL saturate at 16'hFFFF and never wrap.
REQ-025 cyc_cnt SHALL increment every cycle out of reset; ret_cnt SHALL increment per instruction completed in RUN (including the HALT instruction itself); jmp_cnt SHALL increment per J/JZ/JNZ with s_inc=0.
REQ-026 Without UC_PERF_CNT_EN, SHALL keep the counter ports present, tie them to 0, and instantiate no counter flops.

Structure
REQ-027 SHALL place the opcode constants, the ALU Op codes and the state enumeration in shared package uc_pkg.
REQ-028 SHALL implement the combinational opcode decode as sub-module uc_deco, with the state register and counters in uc_fsm.

Verification
REQ-029 Reset release, Opcode=100101 -> Op=001, we3=1, wez=1, s_inc=1, ret_cnt 0->1 at the next edge.
REQ-030 JZ (000001) with z=1 -> s_inc=0, jmp_cnt+1; with z=0 -> s_inc=1, jmp_cnt unchanged.
REQ-031 HALT decoded with start=1 in the same cycle -> halted=1 at the next edge; 3 idle cycles hold s_inc=0; a start pulse -> s_inc=1 that cycle, halted=0 after the edge.
REQ-032 Opcode 000111 -> err=1 after the edge, writes stay 0 under any stimulus, start ignored; reset=0 then 1 -> err=0, state RUN.
REQ-033 With UC_PERF_CNT_EN, 70000 clocks out of reset -> cyc_cnt=16'hFFFF held; without the macro, all counters read 0.
REQ-034 Reset asserted asynchronously mid-cycle while in HALT -> halted=0 and we3=0 immediately, without waiting for a clock edge.
